// File: rtl/regfile_mp.sv
// regfile_mp: general-purpose register file for the rv32i core.
//
// After every reset an INIT sweep writes zero to x1..x(NREG-1), one register
// per cycle, before normal operation (RUN) begins. x0 is hard-wired to zero.
// Writeback always has priority over the debug port. A starvation counter
// raises stall_o so that writeback leaves a gap for a waiting debug request.
//
// Optional feature macro: REGFILE_SCOREBOARD_EN
//   When defined, a per-register busy vector tracks outstanding load results.
//   It adds the sb_set_i / sb_addr_i inputs and the busy_o output.
//
// Ports:
//   clk, rst        core clock; synchronous active-low reset
//   we_i, waddr_i, wdata_i          writeback write port
//   raddr_i, rdata_o                NRD packed combinational read ports
//   sb_set_i, sb_addr_i, busy_o     scoreboard (REGFILE_SCOREBOARD_EN only)
//   init_done_o                     high once the zeroing sweep is complete
//   stall_o                         asks writeback to hold off writes
//   dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i   debug request
//   dbg_gnt_o                       debug access performed this cycle
//   dbg_rvalid_o, dbg_rdata_o       registered debug read-back
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int NRD    = 2,
  parameter int STARVE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic                sb_set_i,
  input  logic [AW-1:0]       sb_addr_i,
  output logic [NRD-1:0]      busy_o,
`endif
  output logic                init_done_o,
  output logic                stall_o,
  input  logic                dbg_req_i,
  input  logic                dbg_we_i,
  input  logic [AW-1:0]       dbg_addr_i,
  input  logic [XLEN-1:0]     dbg_wdata_i,
  output logic                dbg_gnt_o,
  output logic                dbg_rvalid_o,
  output logic [XLEN-1:0]     dbg_rdata_o
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_idx;
  logic            r_init_done;
  logic [XLEN-1:0] r_mem [NREG];
  logic [7:0]      r_starve;
  logic            r_stall;
  logic            r_dbg_rvalid;
  logic [XLEN-1:0] r_dbg_rdata;

  logic            w_run;
  logic            w_wb_wr;
  logic            w_dbg_gnt;
  logic            w_dbg_wr;
  logic [7:0]      w_starve_nxt;
  logic [XLEN-1:0] w_dbg_rdata_nxt;

  assign w_run     = (r_state == ST_RUN);
  // Writes to x0 are dropped here so the array never holds a value for x0.
  assign w_wb_wr   = w_run & we_i & (waddr_i != {AW{1'b0}});
  // Writeback wins: debug is only served in cycles without a writeback write.
  assign w_dbg_gnt = w_run & dbg_req_i & ~we_i;
  assign w_dbg_wr  = w_dbg_gnt & dbg_we_i & (dbg_addr_i != {AW{1'b0}});

  assign dbg_gnt_o    = w_dbg_gnt;
  assign init_done_o  = r_init_done;
  assign stall_o      = r_stall;
  assign dbg_rvalid_o = r_dbg_rvalid;
  assign dbg_rdata_o  = r_dbg_rdata;

  // Control FSM: zeroing sweep over x1..x(NREG-1), then RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_INIT;
      r_idx       <= AW'(1);
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_idx == AW'(NREG - 1)) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end else begin
            r_idx <= r_idx + AW'(1);
          end
        end
        ST_RUN: begin
          r_state     <= ST_RUN;
          r_init_done <= 1'b1;
        end
        default: begin
          r_state     <= ST_INIT;
          r_idx       <= AW'(1);
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

  // Register array: sweep writes in INIT, writeback or granted debug write in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (r_state == ST_INIT) begin
        r_mem[r_idx] <= {XLEN{1'b0}};
      end else if (w_wb_wr) begin
        r_mem[waddr_i] <= wdata_i;
      end else if (w_dbg_wr) begin
        r_mem[dbg_addr_i] <= dbg_wdata_i;
      end
    end
  end

  // Read ports: zero outside RUN and for x0, writeback bypass, else array.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rd;

    assign w_ra = raddr_i[k*AW +: AW];

    // Per-port read mux with same-cycle writeback forwarding.
    always_comb begin
      if (!w_run) begin
        w_rd = {XLEN{1'b0}};
      end else if (w_ra == {AW{1'b0}}) begin
        w_rd = {XLEN{1'b0}};
      end else if (we_i && (waddr_i == w_ra)) begin
        w_rd = wdata_i;
      end else begin
        w_rd = r_mem[w_ra];
      end
    end

    assign rdata_o[k*XLEN +: XLEN] = w_rd;
  end

  // Debug read-back source: a write echoes its own data, a read fetches the array.
  always_comb begin
    if (dbg_we_i) begin
      w_dbg_rdata_nxt = dbg_wdata_i;
    end else if (dbg_addr_i == {AW{1'b0}}) begin
      w_dbg_rdata_nxt = {XLEN{1'b0}};
    end else begin
      w_dbg_rdata_nxt = r_mem[dbg_addr_i];
    end
  end

  // Debug response register: one-cycle valid pulse after each grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dbg_rvalid <= 1'b0;
      r_dbg_rdata  <= {XLEN{1'b0}};
    end else begin
      r_dbg_rvalid <= w_dbg_gnt;
      if (w_dbg_gnt) begin
        r_dbg_rdata <= w_dbg_rdata_nxt;
      end
    end
  end

  // Starvation counter next value: clears on grant or dropped request, saturates at 255.
  always_comb begin
    if (!dbg_req_i || w_dbg_gnt) begin
      w_starve_nxt = 8'd0;
    end else if (r_starve == 8'd255) begin
      w_starve_nxt = r_starve;
    end else begin
      w_starve_nxt = r_starve + 8'd1;
    end
  end

  // Starvation counter and stall flag; the flag is derived from the next count
  // so that it tracks the counter register without an extra cycle of lag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve <= 8'd0;
      r_stall  <= 1'b0;
    end else begin
      r_starve <= w_starve_nxt;
      r_stall  <= (w_starve_nxt >= 8'(STARVE));
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_sb_set;

  assign w_sb_set = w_run & sb_set_i & (sb_addr_i != {AW{1'b0}});

  // Busy vector update: a set on the same address as a clearing write wins.
  always_comb begin
    for (int j = 0; j < NREG; j++) begin
      w_busy_nxt[j] = (w_sb_set && (sb_addr_i == AW'(j))) ? 1'b1 :
                      (w_wb_wr && (waddr_i == AW'(j)))    ? 1'b0 :
                      r_busy[j];
    end
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= {NREG{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Per-port busy flag; a writeback to the same register this cycle hides it.
  for (genvar k = 0; k < NRD; k++) begin : g_busy
    logic [AW-1:0] w_ba;

    assign w_ba = raddr_i[k*AW +: AW];
    assign busy_o[k] = w_run && (w_ba != {AW{1'b0}}) &&
                       !(we_i && (waddr_i == w_ba)) && r_busy[w_ba];
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int AW     = 5;
  localparam int NRD    = 2;
  localparam int STARVE = 8;
  localparam int RAW    = NRD * AW;
  localparam int RDW    = NRD * XLEN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT inputs
  logic            rst;
  logic            we_i;
  logic [AW-1:0]   waddr_i;
  logic [XLEN-1:0] wdata_i;
  logic [RAW-1:0]  raddr_i;
  logic            sb_set_i;
  logic [AW-1:0]   sb_addr_i;
  logic            dbg_req_i;
  logic            dbg_we_i;
  logic [AW-1:0]   dbg_addr_i;
  logic [XLEN-1:0] dbg_wdata_i;
  // DUT outputs
  logic [RDW-1:0]  rdata_o;
  logic [NRD-1:0]  busy_o;
  logic            init_done_o;
  logic            stall_o;
  logic            dbg_gnt_o;
  logic            dbg_rvalid_o;
  logic [XLEN-1:0] dbg_rdata_o;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .STARVE(STARVE)) dut (
    .clk          (clk),
    .rst          (rst),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .wdata_i      (wdata_i),
    .raddr_i      (raddr_i),
    .rdata_o      (rdata_o),
`ifdef REGFILE_SCOREBOARD_EN
    .sb_set_i     (sb_set_i),
    .sb_addr_i    (sb_addr_i),
    .busy_o       (busy_o),
`endif
    .init_done_o  (init_done_o),
    .stall_o      (stall_o),
    .dbg_req_i    (dbg_req_i),
    .dbg_we_i     (dbg_we_i),
    .dbg_addr_i   (dbg_addr_i),
    .dbg_wdata_i  (dbg_wdata_i),
    .dbg_gnt_o    (dbg_gnt_o),
    .dbg_rvalid_o (dbg_rvalid_o),
    .dbg_rdata_o  (dbg_rdata_o)
  );

`ifndef REGFILE_SCOREBOARD_EN
  assign busy_o = '0;
`endif

  // Next-cycle stimulus, applied to the DUT inputs at the falling edge.
  logic            n_rst, n_we, n_sb_set, n_dbg_req, n_dbg_we;
  logic [AW-1:0]   n_waddr, n_sb_addr, n_dbg_addr;
  logic [XLEN-1:0] n_wdata, n_dbg_wdata;
  logic [RAW-1:0]  n_raddr;

  typedef struct {
    logic           init_done;
    logic           stall;
    logic           gnt;
    logic           rvalid;
    logic [RDW-1:0] rdata;
    logic [NRD-1:0] busy;
  } exp_t;

  exp_t            q_exp[$];
  logic [XLEN-1:0] q_dbg[$];

  // Reference model: register contents, cycles since reset, debug wait count.
  logic [XLEN-1:0] m_regs [NREG];
  logic            m_busy [NREG];
  int              m_since;
  int              m_wait;
  logic            m_rvalid;
  logic            m_last_gnt;
  logic            m_known = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    n_rst = 1'b1; n_we = 1'b0; n_waddr = '0; n_wdata = '0; n_raddr = '0;
    n_sb_set = 1'b0; n_sb_addr = '0;
    n_dbg_req = 1'b0; n_dbg_we = 1'b0; n_dbg_addr = '0; n_dbg_wdata = '0;
  endtask

  // One clock cycle: apply stimulus, push expected outputs, advance the model.
  task automatic tick();
    exp_t          e;
    logic          run, gnt;
    logic [AW-1:0] a;
    @(negedge clk);
    rst = n_rst; we_i = n_we; waddr_i = n_waddr; wdata_i = n_wdata; raddr_i = n_raddr;
    sb_set_i = n_sb_set; sb_addr_i = n_sb_addr;
    dbg_req_i = n_dbg_req; dbg_we_i = n_dbg_we; dbg_addr_i = n_dbg_addr; dbg_wdata_i = n_dbg_wdata;

    run = (m_since >= NREG - 1);
    gnt = run && dbg_req_i && !we_i;
    e.init_done = run;
    e.stall     = (m_wait >= STARVE);
    e.gnt       = gnt;
    e.rvalid    = m_rvalid;
    for (int k = 0; k < NRD; k++) begin
      a = raddr_i[k*AW +: AW];
      if (!run || a == 0)            e.rdata[k*XLEN +: XLEN] = '0;
      else if (we_i && waddr_i == a) e.rdata[k*XLEN +: XLEN] = wdata_i;
      else                           e.rdata[k*XLEN +: XLEN] = m_regs[a];
      e.busy[k] = run && (a != 0) && !(we_i && waddr_i == a) && m_busy[a];
    end
    if (m_known) q_exp.push_back(e);

    if (!rst) begin
      m_since = 0; m_wait = 0; m_rvalid = 1'b0; m_last_gnt = 1'b1; m_known = 1'b1;
      for (int j = 0; j < NREG; j++) begin
        m_regs[j] = '0;
        m_busy[j] = 1'b0;
      end
    end else begin
      m_last_gnt = gnt;
      if (!run) m_since++;
      if (run && we_i && waddr_i != 0) begin
        m_regs[waddr_i] = wdata_i;
        m_busy[waddr_i] = 1'b0;
      end
`ifdef REGFILE_SCOREBOARD_EN
      if (run && sb_set_i && sb_addr_i != 0) m_busy[sb_addr_i] = 1'b1;
`endif
      if (gnt) begin
        if (dbg_we_i) begin
          q_dbg.push_back(dbg_wdata_i);
          if (dbg_addr_i != 0) m_regs[dbg_addr_i] = dbg_wdata_i;
        end else begin
          q_dbg.push_back((dbg_addr_i == 0) ? '0 : m_regs[dbg_addr_i]);
        end
      end
      m_rvalid = gnt;
      if (!dbg_req_i || gnt) m_wait = 0;
      else if (m_wait < 255) m_wait++;
    end
  endtask

  // Monitor: samples just before each rising edge and checks against the queues.
  initial begin
    exp_t            e;
    logic [XLEN-1:0] d;
    forever begin
      @(negedge clk);
      #3;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        chk("init_done", 64'(init_done_o), 64'(e.init_done));
        chk("stall", 64'(stall_o), 64'(e.stall));
        chk("dbg_gnt", 64'(dbg_gnt_o), 64'(e.gnt));
        chk("dbg_rvalid", 64'(dbg_rvalid_o), 64'(e.rvalid));
        chk("rdata", 64'(rdata_o), 64'(e.rdata));
`ifdef REGFILE_SCOREBOARD_EN
        chk("busy", 64'(busy_o), 64'(e.busy));
`endif
      end
      if (dbg_rvalid_o === 1'b1) begin
        if (q_dbg.size() == 0) begin
          chk("dbg_rvalid_unexpected", 64'(dbg_rvalid_o), 64'd0);
        end else begin
          d = q_dbg.pop_front();
          chk("dbg_rdata", 64'(dbg_rdata_o), 64'(d));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    // Reset with writeback active; writes during the sweep must be ignored.
    n_rst = 1'b0; n_we = 1'b1; n_waddr = 5'd3; n_wdata = 32'h1234_5678;
    tick(); tick();
    #3;
    chk("rst_dbg_rdata", 64'(dbg_rdata_o), 64'd0);
    n_rst = 1'b1;
    for (int i = 0; i < NREG - 1; i++) begin
      n_we = 1'b1; n_waddr = AW'(i + 1); n_wdata = $urandom;
      n_raddr = RAW'($urandom); n_dbg_req = 1'b1; n_dbg_addr = AW'(i);
      tick();
    end
    set_idle();
    for (int i = 0; i < NREG / 2; i++) begin
      n_raddr = {AW'(i + NREG / 2), AW'(i)};
      tick();
    end
    // Bypass write of x5, then a discarded write to x0.
    n_we = 1'b1; n_waddr = 5'd5; n_wdata = 32'hDEAD_BEEF; n_raddr = {5'd0, 5'd5};
    tick();
    n_we = 1'b1; n_waddr = 5'd0; n_wdata = 32'h0000_0001; n_raddr = {5'd5, 5'd0};
    tick();
    set_idle(); tick();
    // Debug read of x5.
    n_dbg_req = 1'b1; n_dbg_we = 1'b0; n_dbg_addr = 5'd5;
    tick();
    set_idle(); tick(); tick();
    // Starvation: writeback busy for 20 cycles while debug waits.
    for (int i = 0; i < 20; i++) begin
      n_we = 1'b1; n_waddr = 5'd9; n_wdata = $urandom;
      n_dbg_req = 1'b1; n_dbg_we = 1'b0; n_dbg_addr = 5'd5;
      tick();
    end
    n_we = 1'b0; tick();
    set_idle(); tick(); tick();
    // Debug write echo, then read back via debug and a read port.
    n_dbg_req = 1'b1; n_dbg_we = 1'b1; n_dbg_addr = 5'd12; n_dbg_wdata = 32'hCAFE_F00D;
    tick();
    n_dbg_we = 1'b0; n_raddr = {5'd12, 5'd9};
    tick();
    set_idle(); tick();
`ifdef REGFILE_SCOREBOARD_EN
    n_sb_set = 1'b1; n_sb_addr = 5'd7; tick();
    set_idle(); n_raddr = {5'd7, 5'd0}; tick();
    n_we = 1'b1; n_waddr = 5'd7; n_wdata = 32'h0BAD_F00D; tick();
    n_we = 1'b0; tick();
    // Same-cycle set and clear on one address leaves it busy.
    n_sb_set = 1'b1; n_sb_addr = 5'd8; tick();
    n_we = 1'b1; n_waddr = 5'd8; n_wdata = 32'h1; n_raddr = {5'd8, 5'd8}; tick();
    set_idle(); n_raddr = {5'd8, 5'd8}; tick();
    set_idle(); tick();
`endif
    // Reset asserted mid-sweep.
    n_rst = 1'b0; tick();
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_rst = 1'b0; n_dbg_req = 1'b1; tick();
    set_idle();
    for (int i = 0; i < 40; i++) begin
      n_we = 1'b1; n_waddr = AW'($urandom); n_wdata = $urandom; n_raddr = RAW'($urandom);
      tick();
    end
    // Randomised traffic with debug requests held until granted.
    for (int c = 0; c < 600; c++) begin
      n_rst = ($urandom_range(0, 199) != 0);
      n_we = ($urandom_range(0, 2) != 0);
      n_waddr = AW'($urandom_range(0, 15));
      n_wdata = $urandom;
      n_raddr = RAW'($urandom);
      if ($urandom_range(0, 2) == 0) n_raddr[AW-1:0] = n_waddr;
      n_sb_set = $urandom_range(0, 1);
      n_sb_addr = AW'($urandom_range(0, 15));
      if (!n_dbg_req || m_last_gnt) begin
        n_dbg_req = ($urandom_range(0, 2) == 0);
        n_dbg_we = $urandom_range(0, 1);
        n_dbg_addr = AW'($urandom_range(1, 15));
        n_dbg_wdata = $urandom;
      end
      tick();
    end
    set_idle();
    tick(); tick(); tick();
    @(negedge clk);
    #5;
    chk("dbg_queue_drained", 64'(q_dbg.size()), 64'd0);
    chk("exp_queue_drained", 64'(q_exp.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
